fp_add_issue: RTL and testbench

//  Issue/writeback controller for the 1-stage-pipelined fp_adder (inputs sampled on clk, result S valid next cycle).

---
 rtl/fp_pkg.sv | 36 +++
 rtl/fp_result_fifo.sv | 70 +++++++
 rtl/fp_add_issue.sv | 105 ++++++++++
 tb/tb_fp_add_issue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP32 field widths, value classes and decode helpers used by the
// adder issue/writeback logic.
package fp_pkg;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;

    typedef enum logic [2:0] {
        ZERO    = 3'b000,
        SUBNORM = 3'b001,
        INF     = 3'b010,
        NAN     = 3'b011,
        NORMAL  = 3'b100
    } fp_type_t;

    function automatic fp_type_t fp_classify(input logic [FP32_EXP_W-1:0] e,
                                             input logic [FP32_MAN_W-1:0] m);
        if (e == '0)
            return (m == '0) ? ZERO : SUBNORM;
        else if (e == '1)
            return (m == '0) ? INF : NAN;
        else
            return NORMAL;
    endfunction

    function automatic logic is_nan(input logic [FP32_EXP_W-1:0] e,
                                    input logic [FP32_MAN_W-1:0] m);
        return fp_classify(e, m) == NAN;
    endfunction

    function automatic logic is_inf(input logic [FP32_EXP_W-1:0] e,
                                    input logic [FP32_MAN_W-1:0] m);
        return fp_classify(e, m) == INF;
    endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// Small result FIFO with wrapping pointers and a separate occupancy count.
// The head output holds the last popped value while the FIFO is empty.
module fp_result_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [W-1:0]     mem [DEPTH];
    logic [W-1:0]     last;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign dout    = empty ? last : mem[rd_ptr];

    // Push and pop in the same cycle both apply, even when full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            last   <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            if (!empty)
                last <= mem[rd_ptr];
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                last   <= mem[rd_ptr];
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/fp_add_issue.sv
// Issue/writeback controller for a 1-stage pipelined FP32 adder: credit-based
// acceptance, tag pipe alongside the adder, and a result FIFO toward writeback.
module fp_add_issue
    import fp_pkg::*;
#(
    parameter int TAG_W   = 5,
    parameter int DEPTH   = 2,
    parameter int ADD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_sub,
    input  logic [31:0]      add_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_nan,
    output logic             out_inf
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int W     = 32 + TAG_W;

    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               pop;
    logic               push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [W-1:0]       head;
    logic [ADD_LAT-1:0] pipe_vld;
    logic [TAG_W-1:0]   pipe_tag [ADD_LAT];

    assign add_a   = in_a;
    assign add_b   = in_b;
    assign add_sub = in_sub;

    // Ready depends only on the registered credit count, never on out_ready.
    assign in_ready  = ~rst & ~flush & (cnt < CNT_W'(DEPTH));
    assign accept    = in_valid & in_ready;
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready & ~flush;
    assign push      = pipe_vld[ADD_LAT-1] & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (flush)
            cnt <= '0;
        else if (accept && !pop)
            cnt <= cnt + 1'b1;
        else if (!accept && pop)
            cnt <= cnt - 1'b1;
    end

    // Tag pipe mirrors the adder stages so each result meets its tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < ADD_LAT; i++)
                pipe_tag[i] <= '0;
        end else begin
            pipe_vld[0] <= accept;
            pipe_tag[0] <= in_tag;
            for (int i = 1; i < ADD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1] & ~flush;
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    fp_result_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .din   ({add_s, pipe_tag[ADD_LAT-1]}),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_result = head[W-1:TAG_W];
    assign out_tag    = head[TAG_W-1:0];
    assign out_nan    = is_nan(out_result[30:23], out_result[22:0]);
    assign out_inf    = is_inf(out_result[30:23], out_result[22:0]);

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fp_add_issue.sv
// Randomized and directed bench for fp_add_issue with a stand-in 1-cycle adder
// and a queue-based scoreboard tracking accepted ops and their visible cycle.
module tb_fp_add_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic [4:0]  in_tag;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_sub;
    logic [31:0] add_s = 32'd0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_nan;
    logic        out_inf;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
        int          vis;
    } entry_t;

    entry_t sb[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;

    always #5 clk = ~clk;

    fp_add_issue #(.TAG_W(5), .DEPTH(2), .ADD_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sub     (in_sub),
        .in_tag     (in_tag),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sub    (add_sub),
        .add_s      (add_s),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_nan    (out_nan),
        .out_inf    (out_inf)
    );

    // Integer-valued FP32 helpers: exact for the small operands used here.
    function automatic logic [31:0] int_to_fp(input int v);
        logic [31:0] mag;
        int          p;
        if (v == 0) return 32'd0;
        mag = (v < 0) ? 32'(-v) : 32'(v);
        p = 0;
        for (int i = 0; i < 31; i++)
            if (mag[i]) p = i;
        mag = mag << (23 - p);
        return {(v < 0), 8'(127 + p), mag[22:0]};
    endfunction

    function automatic int fp_to_int(input logic [31:0] f);
        logic [31:0] m;
        int          sh;
        if (int'(f[30:23]) < 127) return 0;
        sh = 150 - int'(f[30:23]);
        m  = {8'd0, 1'b1, f[22:0]} >> sh;
        return f[31] ? -int'(m) : int'(m);
    endfunction

    // Behaviour of the adder being wrapped, including its inf-inf NaN code.
    function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub);
        logic [31:0] bn;
        bn = sub ? (b ^ 32'h8000_0000) : b;
        if (a[30:23] == 8'hff && bn[30:23] == 8'hff)
            return (a[31] != bn[31]) ? 32'hFF80_0001 : a;
        if (a[30:23] == 8'hff) return a;
        if (bn[30:23] == 8'hff) return bn;
        return int_to_fp(fp_to_int(a) + fp_to_int(bn));
    endfunction

    always @(posedge clk)
        add_s <= fp_ref(add_a, add_b, add_sub);

    task automatic checkOutput(input string name, input logic [63:0] obs,
                               input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, obs, expv);
        end
    endtask

    // One clock cycle: drive, check against the scoreboard, then advance it.
    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic [4:0] tag, input logic ordy,
                                 input logic fl, input logic [31:0] exp_r);
        logic exp_ir;
        logic exp_ov;
        logic acc;
        logic pp;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
        #2;
        exp_ir = !fl && (sb.size() < 2);
        exp_ov = (sb.size() > 0) && (sb[0].vis <= cyc);
        checkOutput("in_ready", 64'(in_ready), 64'(exp_ir));
        checkOutput("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) begin
            checkOutput("out_result", 64'(out_result), 64'(sb[0].res));
            checkOutput("out_tag", 64'(out_tag), 64'(sb[0].tag));
            checkOutput("out_nan", 64'(out_nan),
                        64'(sb[0].res[30:23] == 8'hff && sb[0].res[22:0] != 0));
            checkOutput("out_inf", 64'(out_inf),
                        64'(sb[0].res[30:23] == 8'hff && sb[0].res[22:0] == 0));
        end
        acc = v && exp_ir;
        pp  = ordy && exp_ov && !fl;
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            if (pp) void'(sb.pop_front());
            if (acc) sb.push_back('{res: exp_r, tag: tag, vis: cyc + 2});
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, ordy, 1'b0, 32'd0);
    endtask

    task automatic randomOp(input logic ordy);
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        a = int_to_fp(int'($urandom_range(0, 2000)));
        b = int_to_fp(int'($urandom_range(0, 2000)));
        s = 1'($urandom_range(0, 1));
        applyStimulus(1'b1, a, b, s, 5'($urandom), ordy, 1'b0, fp_ref(a, b, s));
    endtask

    // Asynchronous reset asserted mid-cycle; everything in flight is dropped.
    task automatic midReset();
        rst      = 1'b1;
        in_valid = 1'b1;
        #2;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        sb.delete();
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        in_sub    = 1'b0;
        in_tag    = 5'd0;
        out_ready = 1'b0;
        #3;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_result", 64'(out_result), 64'd0);
        checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
        checkOutput("reset_flags", 64'({out_nan, out_inf}), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] directed: add, sub, back-to-back");
        applyStimulus(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd3, 1'b1, 1'b0, 32'h4040_0000);
        idle(3, 1'b1);
        applyStimulus(1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b1, 5'd7, 1'b1, 1'b0, 32'h4000_0000);
        for (int i = 0; i < 8; i++) randomOp(1'b1);
        idle(3, 1'b1);

        $display("[TB] directed: backpressure and full credit");
        applyStimulus(1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 5'd1, 1'b0, 1'b0, 32'h4000_0000);
        applyStimulus(1'b1, 32'h4000_0000, 32'h3F80_0000, 1'b0, 5'd2, 1'b0, 1'b0, 32'h4040_0000);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 32'h4040_0000, 32'h4040_0000, 1'b0, 5'd4, 1'b0, 1'b0, 32'h40C0_0000);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 32'h4040_0000, 32'h4040_0000, 1'b0, 5'd4, 1'b1, 1'b0, 32'h40C0_0000);
        idle(4, 1'b1);

        $display("[TB] directed: infinities");
        applyStimulus(1'b1, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 5'd9, 1'b1, 1'b0, 32'hFF80_0001);
        applyStimulus(1'b1, 32'h7F80_0000, 32'h3F80_0000, 1'b0, 5'd10, 1'b1, 1'b0, 32'h7F80_0000);
        idle(4, 1'b1);

        $display("[TB] directed: flush and reset with ops in flight");
        randomOp(1'b0);
        randomOp(1'b0);
        applyStimulus(1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 5'd5, 1'b1, 1'b1, 32'h4000_0000);
        idle(5, 1'b1);
        randomOp(1'b0);
        randomOp(1'b0);
        midReset();
        idle(5, 1'b1);

        $display("[TB] random phase");
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                midReset();
            end else if ($urandom_range(0, 49) == 0) begin
                applyStimulus(1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 5'd0,
                              1'($urandom_range(0, 1)), 1'b1, 32'h4000_0000);
            end else if ($urandom_range(0, 3) != 0) begin
                randomOp($urandom_range(0, 9) < 7);
            end else begin
                idle(1, $urandom_range(0, 9) < 7);
            end
        end
        idle(6, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
